// File: rtl/tff_mod_counter.sv
// tff_mod_counter
//
// Synchronous modulo-MOD up/down counter in toggle form. Each cycle it
// computes the next count, exposes the per-bit toggle vector t = q ^ next,
// and updates the state bits only as q <= q ^ t. This is the control stage
// that drives the T flip-flop bank. It also provides parallel load, a
// terminal-count flag, a registered wrap pulse and a one-shot halt mode.
//
// Build option:
//   TFF_CNT_DOWN_EN - when defined, 'up' selects the direction and the
//                     down-count and down-wrap logic is compiled in. When
//                     undefined, the counter only counts up and 'up' is
//                     ignored.
//
// Parameters: WIDTH sets the counter width in bits, and the modulus
// parameter (between 2 and 2**WIDTH) bounds the counts to 0..MOD-1.
//
// Ports:
//   clk     - clock; all state updates on the rising edge
//   clrn    - asynchronous active-low reset
//   en      - count enable
//   up      - direction (1 = up, 0 = down)
//   ld      - synchronous parallel load
//   d       - load value; values >= MOD load as MOD-1
//   oneshot - halt at terminal instead of wrapping
//   q       - count
//   qn      - ~q
//   t       - toggle vector applied at the next edge
//   tc      - terminal count (combinational)
//   wrap    - one-cycle pulse in the cycle after a wrapping edge
//   done    - high while halted
module tff_mod_counter #(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             en,
   input  logic             up,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   input  logic             oneshot,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic [WIDTH-1:0] t,
   output logic             tc,
   output logic             wrap,
   output logic             done
);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   // Arithmetic is carried out one bit wider so MOD itself (which may be
   // 2**WIDTH) is representable.
   localparam logic [WIDTH:0] MOD_W   = (WIDTH+1)'(MOD);
   localparam logic [WIDTH:0] MODM1_W = (WIDTH+1)'(MOD - 1);

   state_t           state, state_next;
   logic [WIDTH-1:0] q_next;
   logic             wrap_next;
   logic [WIDTH-1:0] terminal;
   logic [WIDTH:0]   q_ext;
   logic [WIDTH:0]   q_inc;
   logic [WIDTH-1:0] d_clamped;
   logic             dir_up;

   assign q_ext = {1'b0, q};
   assign q_inc = q_ext + 1'b1;

`ifdef TFF_CNT_DOWN_EN
   logic [WIDTH:0] q_dec;

   assign dir_up   = up;
   assign q_dec    = q_ext - 1'b1;
   assign terminal = dir_up ? MODM1_W[WIDTH-1:0] : '0;
`else
   // Up-only build: direction is forced up; 'up' is folded in only so the
   // port stays referenced.
   assign dir_up   = up | 1'b1;
   assign terminal = MODM1_W[WIDTH-1:0];
`endif

   // Out-of-range load values saturate to the top count.
   assign d_clamped = ({1'b0, d} >= MOD_W) ? MODM1_W[WIDTH-1:0] : d;

   assign tc = en & (state == RUN) & (q == terminal);

   always_comb begin
      q_next     = q;
      state_next = state;
      wrap_next  = 1'b0;
      if (ld) begin
         // Load wins over any count or terminal event and always resumes RUN.
         q_next     = d_clamped;
         state_next = RUN;
      end else if (state == RUN && en) begin
         if (!tc) begin
`ifdef TFF_CNT_DOWN_EN
            q_next = dir_up ? q_inc[WIDTH-1:0] : q_dec[WIDTH-1:0];
`else
            q_next = q_inc[WIDTH-1:0];
`endif
         end else if (!oneshot) begin
`ifdef TFF_CNT_DOWN_EN
            q_next = dir_up ? '0 : MODM1_W[WIDTH-1:0];
`else
            q_next = '0;
`endif
            wrap_next = 1'b1;
         end else begin
            state_next = HALT;
         end
      end
   end

   assign t    = q ^ q_next;
   assign qn   = ~q;
   assign done = (state == HALT);

   // State register: bits change only by toggling.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         q     <= '0;
         state <= RUN;
         wrap  <= 1'b0;
      end else begin
         q     <= q ^ t;
         state <= state_next;
         wrap  <= wrap_next;
      end
   end

endmodule

// File: tb/tb_tff_mod_counter.sv
module tb_tff_mod_counter;

   logic       clk = 1'b0;
   logic       clrn;
   logic       en;
   logic       up;
   logic       ld;
   logic [3:0] d;
   logic       oneshot;
   logic [3:0] q;
   logic [3:0] qn;
   logic [3:0] t;
   logic       tc;
   logic       wrap;
   logic       done;

   int checks   = 0;
   int failures = 0;

   tff_mod_counter #(.WIDTH(4), .MOD(10)) dut (
      .clk     (clk),
      .clrn    (clrn),
      .en      (en),
      .up      (up),
      .ld      (ld),
      .d       (d),
      .oneshot (oneshot),
      .q       (q),
      .qn      (qn),
      .t       (t),
      .tc      (tc),
      .wrap    (wrap),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clrn = 1'b0; en = 1'b0; up = 1'b1; ld = 1'b0; d = 4'd0; oneshot = 1'b0;
      #3;
      check("reset_q", 32'(q), 32'h0);
      check("reset_qn", 32'(qn), 32'hF);
      check("reset_wrap", 32'(wrap), 32'h0);
      check("reset_done", 32'(done), 32'h0);
      check("reset_tc", 32'(tc), 32'h0);
      clrn = 1'b1;

      // Up count through a full wrap.
      step();
      en = 1'b1; up = 1'b1;
      #1;
      check("t_at_0", 32'(t), 32'h1);
      for (int i = 1; i <= 9; i++) begin
         step();
         check($sformatf("up_q%0d", i), 32'(q), 32'(i));
      end
      check("tc_at_9", 32'(tc), 32'h1);
      check("t_at_9", 32'(t), 32'h9);
      check("nowrap_at_9", 32'(wrap), 32'h0);
      step();
      check("up_wrap_q", 32'(q), 32'h0);
      check("up_wrap_pulse", 32'(wrap), 32'h1);
      check("tc_at_0_up", 32'(tc), 32'h0);
      step();
      check("up_after_wrap_q", 32'(q), 32'h1);
      check("wrap_one_cycle", 32'(wrap), 32'h0);

      // Asynchronous reset mid-count at q=7.
      for (int i = 0; i < 6; i++) step();
      check("pre_reset_q7", 32'(q), 32'h7);
      clrn = 1'b0;
      #2;
      check("async_reset_q", 32'(q), 32'h0);
      check("async_reset_qn", 32'(qn), 32'hF);
      check("async_reset_wrap", 32'(wrap), 32'h0);
      check("async_reset_done", 32'(done), 32'h0);
      en = 1'b0;
      #1;
      clrn = 1'b1;

      // Load clamp.
      ld = 1'b1; d = 4'd13;
      step();
      ld = 1'b0;
      check("load_clamp_q", 32'(q), 32'h9);

      // Load beats a terminal wrap.
      en = 1'b1; up = 1'b1;
      #1;
      check("tc_before_ld", 32'(tc), 32'h1);
      ld = 1'b1; d = 4'd4;
      step();
      ld = 1'b0;
      check("ld_priority_q", 32'(q), 32'h4);
      check("ld_priority_nowrap", 32'(wrap), 32'h0);

      // One-shot from 7.
      en = 1'b0; ld = 1'b1; d = 4'd7;
      step();
      ld = 1'b0;
      check("os_load7", 32'(q), 32'h7);
      en = 1'b1; oneshot = 1'b1;
      step();
      check("os_q8", 32'(q), 32'h8);
      step();
      check("os_q9", 32'(q), 32'h9);
      check("os_done_low_at_9", 32'(done), 32'h0);
      step();
      check("os_hold_q", 32'(q), 32'h9);
      check("os_done", 32'(done), 32'h1);
      check("os_no_wrap", 32'(wrap), 32'h0);
      check("os_tc_halt", 32'(tc), 32'h0);
      check("os_t_halt", 32'(t), 32'h0);
      for (int i = 0; i < 5; i++) step();
      check("os_hold_after5", 32'(q), 32'h9);
      check("os_done_after5", 32'(done), 32'h1);
      ld = 1'b1; d = 4'd2;
      step();
      ld = 1'b0;
      check("os_reload_q", 32'(q), 32'h2);
      check("os_reload_done", 32'(done), 32'h0);
      oneshot = 1'b0;
      step();
      check("os_resume_count", 32'(q), 32'h3);

`ifdef TFF_CNT_DOWN_EN
      // Down count and down wrap from 1.
      en = 1'b0; ld = 1'b1; d = 4'd1;
      step();
      ld = 1'b0;
      en = 1'b1; up = 1'b0;
      step();
      check("down_q0", 32'(q), 32'h0);
      check("down_tc_at_0", 32'(tc), 32'h1);
      up = 1'b1;
      #1;
      check("tc_dir_change", 32'(tc), 32'h0);
      up = 1'b0;
      step();
      check("down_wrap_q", 32'(q), 32'h9);
      check("down_wrap_pulse", 32'(wrap), 32'h1);
      step();
      check("down_q8", 32'(q), 32'h8);
      check("down_wrap_one_cycle", 32'(wrap), 32'h0);
`else
      // Up-only build: up=0 still counts up.
      en = 1'b0; ld = 1'b1; d = 4'd3;
      step();
      ld = 1'b0;
      en = 1'b1; up = 1'b0;
      step();
      check("uponly_q4", 32'(q), 32'h4);
      step();
      check("uponly_q5", 32'(q), 32'h5);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety bound so the run always ends.
   initial begin
      #20000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
